// File: rtl/uart_rom_tx_if.sv
// rtl/uart_rom_tx_if.sv - start/ROM/serial-line bundle between the message sequencer and its neighbours
interface uart_rom_tx_if;
   logic       start;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic       tx;
   logic       busy;
   logic       done;

   modport master (
      input  start,
      input  rom_data,
      output rom_addr,
      output tx,
      output busy,
      output done
   );

   modport slave (
      output start,
      output rom_data,
      input  rom_addr,
      input  tx,
      input  busy,
      input  done
   );
endinterface

// File: rtl/uart_rom_tx.sv
// rtl/uart_rom_tx.sv - ROM message sequencer and 8N1 serializer
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_rom_tx #(
   parameter int CLK_DIV = 434,
   parameter int MSG_LEN = 10
) (
   input logic          CLOCK,
   input logic          RESET_N,
   uart_rom_tx_if.master port
);

   localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [3:0]        LAST_IDX  = 4'(MSG_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          index_q, index_d;
   logic [3:0]          addr_q, addr_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
   logic                par_q, par_d;
`endif
   logic                bit_end;

   assign bit_end = (baud_q == BAUD_LAST);

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         index_q <= '0;
         addr_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         addr_q  <= addr_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      addr_d  = addr_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (port.start) begin
               state_d = S_FETCH;
               index_d = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
            end
         end

         S_FETCH: begin
            state_d = S_WAIT;
         end

         // ROM output is valid now; the start bit goes out on this edge.
         S_WAIT: begin
            shift_d = port.rom_data;
`ifdef UART_TX_PARITY_EN
            par_d   = ^port.rom_data;
`endif
            tx_d    = 1'b0;
            baud_d  = '0;
            state_d = S_START;
         end

         S_START: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = '0;
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = S_STOP;
            end
         end
`endif

         S_STOP: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               tx_d = 1'b1;
               if (index_q != LAST_IDX) begin
                  index_d = index_q + 4'd1;
                  addr_d  = index_q + 4'd1;
                  state_d = S_FETCH;
               end else begin
                  index_d = '0;
                  addr_d  = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign port.rom_addr = addr_q;
   assign port.tx       = tx_q;
   assign port.busy     = busy_q;
   assign port.done     = done_q;

endmodule

// File: tb/tb_uart_rom_tx.sv
// tb/tb_uart_rom_tx.sv - directed bench for uart_rom_tx (three parameter sets, registered ROM models)
`timescale 1ns/1ps
module tb_uart_rom_tx;

   localparam int CD_A = 4;
   localparam int ML_A = 10;
   localparam int CD_B = 2;
   localparam int ML_B = 3;
   localparam int CD_C = 2;
   localparam int ML_C = 1;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int BYTE_A = 2 + NB * CD_A;
   localparam int BYTE_B = 2 + NB * CD_B;
   localparam int BYTE_C = 2 + NB * CD_C;

   logic CLOCK = 1'b0;
   logic RESET_N = 1'b0;
   always #5 CLOCK = ~CLOCK;

   uart_rom_tx_if ifa ();
   uart_rom_tx_if ifb ();
   uart_rom_tx_if ifc ();

   uart_rom_tx #(.CLK_DIV(CD_A), .MSG_LEN(ML_A)) dut_a (.CLOCK(CLOCK), .RESET_N(RESET_N), .port(ifa));
   uart_rom_tx #(.CLK_DIV(CD_B), .MSG_LEN(ML_B)) dut_b (.CLOCK(CLOCK), .RESET_N(RESET_N), .port(ifb));
   uart_rom_tx #(.CLK_DIV(CD_C), .MSG_LEN(ML_C)) dut_c (.CLOCK(CLOCK), .RESET_N(RESET_N), .port(ifc));

   logic [7:0] rom_b [16];

   always @(posedge CLOCK) begin
      ifa.rom_data <= 8'h8B;
      ifb.rom_data <= rom_b[ifb.rom_addr];
      ifc.rom_data <= 8'h8B;
   end

   typedef struct {
      int         cyc;
      logic       tx;
      logic [3:0] addr;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge CLOCK);
      @(negedge CLOCK);
      cyc++;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB-1:0] frame;
      logic [7:0]    got;
      int            ndone, first, t1, t2;
      logic          all_high, any_busy;

      ifa.start = 1'b0;
      ifb.start = 1'b0;
      ifc.start = 1'b0;
      for (int i = 0; i < 16; i++) rom_b[i] = 8'(i);
      cyc = 0;

`ifdef UART_TX_PARITY_EN
      frame = 11'b101_0001_0110;
`else
      frame = 10'b11_0001_0110;
`endif
      tbl.push_back('{0, 1'b1, 4'd0, 1'b1, 1'b0});
      tbl.push_back('{1, 1'b1, 4'd0, 1'b1, 1'b0});
      for (int i = 0; i < NB; i++) begin
         tbl.push_back('{2 + i * CD_A,            frame[i], 4'd0, 1'b1, 1'b0});
         tbl.push_back('{2 + i * CD_A + CD_A - 1, frame[i], 4'd0, 1'b1, 1'b0});
      end
      for (int j = 1; j < ML_A; j++) begin
         tbl.push_back('{j * BYTE_A,              1'b1, 4'(j), 1'b1, 1'b0});
         tbl.push_back('{j * BYTE_A + 1,          1'b1, 4'(j), 1'b1, 1'b0});
         tbl.push_back('{j * BYTE_A + 2,          1'b0, 4'(j), 1'b1, 1'b0});
         tbl.push_back('{j * BYTE_A + BYTE_A - 1, 1'b1, 4'(j), 1'b1, 1'b0});
      end
      tbl.push_back('{ML_A * BYTE_A,     1'b1, 4'd0, 1'b0, 1'b1});
      tbl.push_back('{ML_A * BYTE_A + 1, 1'b1, 4'd0, 1'b0, 1'b0});

      // Reset state
      @(negedge CLOCK);
      @(negedge CLOCK);
      check("rst_tx",   ifa.tx, 1);
      check("rst_busy", ifa.busy, 0);
      check("rst_done", ifa.done, 0);
      check("rst_addr", ifa.rom_addr, 0);
      RESET_N = 1'b1;
      step();
      step();

      // Default frame, table-driven
      cyc = -1;
      ifa.start = 1'b1;
      step();
      ifa.start = 1'b0;
      foreach (tbl[k]) begin
         run_to(tbl[k].cyc);
         check("tbl_tx",   ifa.tx,       tbl[k].tx);
         check("tbl_addr", ifa.rom_addr, tbl[k].addr);
         check("tbl_busy", ifa.busy,     tbl[k].busy);
         check("tbl_done", ifa.done,     tbl[k].done);
      end
      step();
      step();

      // Busy handshake: start mid-message is ignored
      cyc = -1;
      ifa.start = 1'b1;
      step();
      ifa.start = 1'b0;
      ndone = 0;
      first = -1;
      for (int i = 0; i < ML_A * BYTE_A + 40; i++) begin
         if (i == 100) ifa.start = 1'b1;
         if (i == 101) ifa.start = 1'b0;
         if (ifa.done) begin
            ndone++;
            if (first < 0) first = cyc;
         end
         step();
      end
      check("single_done", ndone, 1);
      check("done_cycle", first, ML_A * BYTE_A);

      // start held high: back-to-back messages
      ifa.start = 1'b1;
      cyc = 0;
      t1 = -1;
      t2 = -1;
      for (int i = 0; i < 3 * ML_A * BYTE_A && t2 < 0; i++) begin
         step();
         if (ifa.done) begin
            if (t1 < 0) t1 = cyc;
            else t2 = cyc;
         end
      end
      ifa.start = 1'b0;
      check("held_period", t2 - t1, ML_A * BYTE_A + 1);
      step();
      step();
      check("held_stop_busy", ifa.busy, 0);

      // Addressing: mem[i] = i
      cyc = -1;
      ifb.start = 1'b1;
      step();
      ifb.start = 1'b0;
      for (int j = 0; j < ML_B; j++) begin
         run_to(j * BYTE_B + 2);
         check("b_start_bit", ifb.tx, 0);
         check("b_addr", ifb.rom_addr, j);
         got = '0;
         for (int i = 0; i < 8; i++) begin
            run_to(j * BYTE_B + 2 + (i + 1) * CD_B + 1);
            got[i] = ifb.tx;
         end
         check("b_byte", got, j);
`ifdef UART_TX_PARITY_EN
         run_to(j * BYTE_B + 2 + 9 * CD_B);
         check("b_parity", ifb.tx, ^(8'(j)));
`endif
      end
      run_to(ML_B * BYTE_B);
      check("b_done", ifb.done, 1);
      check("b_addr_back", ifb.rom_addr, 0);

      // Single byte at minimum divisor
      cyc = -1;
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      first = -1;
      for (int i = 0; i < 200 && first < 0; i++) begin
         if (ifc.done) first = cyc;
         else step();
      end
      check("c_done_cycle", first, BYTE_C);
      check("c_busy_low", ifc.busy, 0);

      // Asynchronous reset mid-DATA
      step();
      cyc = -1;
      ifa.start = 1'b1;
      step();
      ifa.start = 1'b0;
      run_to(2 * BYTE_A + 14);
      check("pre_rst_tx", ifa.tx, 0);
      check("pre_rst_addr", ifa.rom_addr, 2);
      #2 RESET_N = 1'b0;
      #1;
      check("arst_tx",   ifa.tx, 1);
      check("arst_busy", ifa.busy, 0);
      check("arst_done", ifa.done, 0);
      check("arst_addr", ifa.rom_addr, 0);
      @(negedge CLOCK);
      RESET_N = 1'b1;
      all_high = 1'b1;
      any_busy = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (ifa.tx !== 1'b1) all_high = 1'b0;
         if (ifa.busy !== 1'b0) any_busy = 1'b1;
      end
      check("post_rst_tx_high", all_high, 1);
      check("post_rst_no_busy", any_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
